// File: rtl/face_filter_pkg.sv
// Shared types and helpers for the feature-memory read/write-back paths.
package face_filter_pkg;

    // Load sequencer states.
    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_REQ  = 2'd1,
        RF_WAIT = 2'd2,
        RF_DONE = 2'd3
    } rf_state_t;

    localparam int DEF_MEM_DATA_WIDTH = 64;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int MEM_BYTES          = DEF_MEM_DATA_WIDTH / DEF_DATA_WIDTH;

    // Integer ceiling division, used for words-per-column.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/read_fetch.sv
// Memory-to-array loader: fetches an n x n byte tile column by column
// (one outstanding read at a time) and unpacks each word into a 2-D buffer.
module read_fetch
    import face_filter_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ARRAY_SIZE     = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   clr,
    input  logic                                                   start,
    input  logic [ADDR_WIDTH-1:0]                                  base_input_addr,
    input  logic [ADDR_WIDTH-1:0]                                  stride_chan,
    input  logic [4:0]                                             activated_FIFO_num,
    output logic                                                   rd_en,
    output logic [ADDR_WIDTH-1:0]                                  rd_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                              rd_data,
    input  logic                                                   rd_valid,
    output logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  buf_out,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int BYTES = MEM_DATA_WIDTH / DATA_WIDTH;
    localparam int IDX_W = $clog2(ARRAY_SIZE);
    localparam int CNT_W = IDX_W + 1;

    rf_state_t                                             state_q, state_d;
    logic [4:0]                                            n_q, n_d;
    logic [ADDR_WIDTH-1:0]                                 stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]                                 col_base_q, col_base_d;
    logic [ADDR_WIDTH-1:0]                                 rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]                                      col_q, col_d;
    logic [CNT_W-1:0]                                      word_q, word_d;
    logic [CNT_W-1:0]                                      last_word_q, last_word_d;
    logic                                                  rd_en_q, rd_en_d;
    logic                                                  busy_q, busy_d;
    logic                                                  done_q, done_d;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

    logic [4:0]                                            n_clamp_s;
    logic [CNT_W-1:0]                                      last_word_calc_s;
    logic                                                  clear_buf_s;
    logic                                                  capture_s;
    logic [BYTES-1:0]                                      byte_we_s;
    logic [BYTES-1:0][IDX_W-1:0]                           byte_row_s;

    assign n_clamp_s = (int'(activated_FIFO_num) > ARRAY_SIZE) ? 5'(ARRAY_SIZE)
                                                               : activated_FIFO_num;
    // Index of the last word of a column (W-1); irrelevant when n = 0.
    assign last_word_calc_s = (n_clamp_s == 5'd0) ? '0
                            : CNT_W'(ceil_div(32'(n_clamp_s), 32'(BYTES)) - 32'd1);

    // A clear in the same cycle as rd_valid drops the in-flight word.
    assign capture_s = (state_q == RF_WAIT) && rd_valid && !clr;

    // Per-byte row index and write enable; bytes landing at row >= n are dropped.
    for (genvar i = 0; i < BYTES; i++) begin : g_unpack
        logic [31:0] row_full_s;
        assign row_full_s    = 32'(word_q) * 32'(BYTES) + 32'(i);
        assign byte_we_s[i]  = capture_s && (row_full_s < 32'(n_q));
        assign byte_row_s[i] = row_full_s[IDX_W-1:0];
    end

    // Sequencer next-state: config latch, address walk and completion.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        stride_d    = stride_q;
        col_base_d  = col_base_q;
        rd_addr_d   = rd_addr_q;
        col_d       = col_q;
        word_d      = word_q;
        last_word_d = last_word_q;
        rd_en_d     = 1'b0;
        clear_buf_s = 1'b0;
        if (clr) begin
            state_d     = RF_IDLE;
            n_d         = 5'd0;
            stride_d    = '0;
            col_base_d  = '0;
            rd_addr_d   = '0;
            col_d       = '0;
            word_d      = '0;
            last_word_d = '0;
            clear_buf_s = 1'b1;
        end else begin
            case (state_q)
                RF_IDLE, RF_DONE: begin
                    if (start) begin
                        n_d         = n_clamp_s;
                        stride_d    = stride_chan;
                        col_base_d  = base_input_addr;
                        rd_addr_d   = base_input_addr;
                        col_d       = '0;
                        word_d      = '0;
                        last_word_d = last_word_calc_s;
                        clear_buf_s = 1'b1;
                        if (n_clamp_s == 5'd0) begin
                            state_d = RF_DONE;
                        end else begin
                            state_d = RF_REQ;
                            rd_en_d = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RF_REQ: begin
                    state_d = RF_WAIT;
                end
                RF_WAIT: begin
                    if (rd_valid) begin
                        if (word_q == last_word_q) begin
                            if (32'(col_q) == 32'(n_q) - 32'd1) begin
                                state_d = RF_DONE;
                            end else begin
                                word_d     = '0;
                                col_d      = col_q + CNT_W'(1);
                                col_base_d = col_base_q + stride_q;
                                rd_addr_d  = col_base_q + stride_q;
                                state_d    = RF_REQ;
                                rd_en_d    = 1'b1;
                            end
                        end else begin
                            word_d    = word_q + CNT_W'(1);
                            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                            state_d   = RF_REQ;
                            rd_en_d   = 1'b1;
                        end
                    end else begin
                        state_d = RF_WAIT;
                    end
                end
                default: begin
                    state_d = RF_IDLE;
                end
            endcase
        end
        busy_d = (state_d == RF_REQ) || (state_d == RF_WAIT);
        done_d = (state_d == RF_DONE);
    end

    // Tile buffer update: clear on start/clr, otherwise scatter captured bytes into the current column.
    always_comb begin
        buf_d = buf_q;
        if (clear_buf_s) begin
            buf_d = '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                buf_d[byte_row_s[i]][col_q[IDX_W-1:0]] =
                    byte_we_s[i] ? rd_data[i*DATA_WIDTH +: DATA_WIDTH]
                                 : buf_d[byte_row_s[i]][col_q[IDX_W-1:0]];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RF_IDLE;
            n_q         <= 5'd0;
            stride_q    <= '0;
            col_base_q  <= '0;
            rd_addr_q   <= '0;
            col_q       <= '0;
            word_q      <= '0;
            last_word_q <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            stride_q    <= stride_d;
            col_base_q  <= col_base_d;
            rd_addr_q   <= rd_addr_d;
            col_q       <= col_d;
            word_q      <= word_d;
            last_word_q <= last_word_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            buf_q       <= buf_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign buf_out = buf_q;

endmodule

// File: tb/tb_read_fetch.sv
// Directed bench for read_fetch: drives/samples on the falling edge, emulates
// a one-outstanding-request memory and checks addresses, timing and tile contents.
module tb_read_fetch;

    logic                          clk;
    logic                          rst;
    logic                          clr;
    logic                          start;
    logic [7:0]                    base_input_addr;
    logic [7:0]                    stride_chan;
    logic [4:0]                    activated_FIFO_num;
    logic                          rd_en;
    logic [7:0]                    rd_addr;
    logic [63:0]                   rd_data;
    logic                          rd_valid;
    logic [15:0][15:0][7:0]        buf_out;
    logic                          busy;
    logic                          done;

    int checks;
    int fails;

    read_fetch #(
        .MEM_DATA_WIDTH(64),
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .ARRAY_SIZE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .start(start),
        .base_input_addr(base_input_addr),
        .stride_chan(stride_chan),
        .activated_FIFO_num(activated_FIFO_num),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .buf_out(buf_out),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image: byte k of word a = (8a + k) ^ 0x5A.
    function automatic logic [63:0] mem_word(input int a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*8 +: 8] = 8'(((a & 255) * 8 + k)) ^ 8'h5A;
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_byte(input int nc, input int base, input int stride,
                                            input int r, input int c);
        logic [63:0] w;
        if (r < nc && c < nc) begin
            w = mem_word((base + c * stride + r / 8) & 255);
            return w[(r % 8) * 8 +: 8];
        end
        return 8'h00;
    endfunction

    task automatic check_buf(input int nc, input int base, input int stride);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                chk($sformatf("buf[%0d][%0d]", r, c), 64'(buf_out[r][c]),
                    64'(exp_byte(nc, base, stride, r, c)));
            end
        end
    endtask

    // One load; abort_at >= 0 raises clr in the WAIT of that read index.
    task automatic run_load(input int n, input int base, input int stride, input int lat,
                            input int abort_at, input bit glitch);
        int nc;
        int w;
        int idx;
        int a;
        nc  = (n > 16) ? 16 : n;
        w   = (nc + 7) / 8;
        idx = 0;
        @(negedge clk);
        start              = 1'b1;
        activated_FIFO_num = 5'(n);
        base_input_addr    = 8'(base);
        stride_chan        = 8'(stride);
        @(negedge clk);
        start = 1'b0;
        if (nc == 0) begin
            chk("n0_done", 64'(done), 64'd1);
            chk("n0_busy", 64'(busy), 64'd0);
            for (int k = 0; k < 3; k++) begin
                chk("n0_rd_en", 64'(rd_en), 64'd0);
                @(negedge clk);
            end
            chk("n0_done_hold", 64'(done), 64'd1);
            return;
        end
        for (int c = 0; c < nc; c++) begin
            for (int wd = 0; wd < w; wd++) begin
                a = (base + c * stride + wd) & 255;
                chk($sformatf("rd_en#%0d", idx), 64'(rd_en), 64'd1);
                chk($sformatf("rd_addr#%0d", idx), 64'(rd_addr), 64'(a));
                chk($sformatf("busy#%0d", idx), 64'(busy), 64'd1);
                if (glitch && idx == 3) begin
                    start              = 1'b1;
                    activated_FIFO_num = 5'd2;
                    base_input_addr    = 8'h77;
                end
                for (int d = 1; d <= lat; d++) begin
                    @(negedge clk);
                    start = 1'b0;
                    chk($sformatf("wait_rd_en#%0d", idx), 64'(rd_en), 64'd0);
                    if (abort_at == idx) begin
                        clr = 1'b1;
                        @(negedge clk);
                        clr = 1'b0;
                        chk("clr_busy", 64'(busy), 64'd0);
                        chk("clr_done", 64'(done), 64'd0);
                        chk("clr_rd_en", 64'(rd_en), 64'd0);
                        check_buf(0, 0, 0);
                        rd_valid = 1'b1;
                        rd_data  = mem_word(a);
                        @(negedge clk);
                        rd_valid = 1'b0;
                        rd_data  = 64'd0;
                        chk("late_busy", 64'(busy), 64'd0);
                        chk("late_rd_en", 64'(rd_en), 64'd0);
                        check_buf(0, 0, 0);
                        return;
                    end
                    if (glitch && idx == 5 && d == 1) begin
                        start           = 1'b1;
                        base_input_addr = 8'h33;
                    end
                    if (d == lat) begin
                        rd_valid = 1'b1;
                        rd_data  = mem_word(a);
                    end
                end
                @(negedge clk);
                rd_valid = 1'b0;
                rd_data  = 64'd0;
                start    = 1'b0;
                idx++;
            end
        end
        chk("end_done", 64'(done), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_rd_en", 64'(rd_en), 64'd0);
        check_buf(nc, base, stride);
    endtask

    initial begin
        checks             = 0;
        fails              = 0;
        rst                = 1'b1;
        clr                = 1'b0;
        start              = 1'b0;
        base_input_addr    = 8'd0;
        stride_chan        = 8'd0;
        activated_FIFO_num = 5'd0;
        rd_data            = 64'd0;
        rd_valid           = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        check_buf(0, 0, 0);

        // rd_valid while idle must not touch the buffer
        rd_valid = 1'b1;
        rd_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rd_valid = 1'b0;
        rd_data  = 64'd0;
        chk("idle_valid_busy", 64'(busy), 64'd0);
        chk("idle_valid_done", 64'(done), 64'd0);
        check_buf(0, 0, 0);

        run_load(16, 0, 2, 1, -1, 1'b0);
        run_load(5, 10, 4, 1, -1, 1'b0);
        run_load(9, 250, 3, 3, -1, 1'b0);
        run_load(0, 40, 1, 1, -1, 1'b0);
        run_load(20, 3, 2, 1, -1, 1'b0);
        run_load(16, 0, 2, 2, 4, 1'b0);
        run_load(5, 10, 4, 1, -1, 1'b0);
        run_load(9, 250, 3, 2, -1, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
